// File: rtl/ahbl_sram_slave_pkg.sv
// Shared AHB-Lite widths, bus encodings and the slave state type for the SRAM slave.
package ahbl_package;

   localparam int ADDR_WIDTH  = 32;
   localparam int WDATA_WIDTH = 32;
   localparam int SIZE_WIDTH  = 3;
   localparam int BURST_WIDTH = 3;
   localparam int TRANS_WIDTH = 2;
   localparam int PROT_WIDTH  = 4;

   localparam logic [TRANS_WIDTH-1:0] TRANS_IDLE   = 2'd0;
   localparam logic [TRANS_WIDTH-1:0] TRANS_BUSY   = 2'd1;
   localparam logic [TRANS_WIDTH-1:0] TRANS_NONSEQ = 2'd2;
   localparam logic [TRANS_WIDTH-1:0] TRANS_SEQ    = 2'd3;

   localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 3'd0;
   localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 3'd1;
   localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 3'd2;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

   // Little-endian lane enables for an already-validated size/offset pair.
   function automatic logic [3:0] lane_strobe(input logic [SIZE_WIDTH-1:0] size,
                                              input logic [1:0] offset);
      logic [3:0] strb;
      strb = 4'b0000;
      case (size)
         SIZE_BYTE: strb = 4'b0001 << offset;
         SIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: strb = 4'b1111;
         default:   strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/ahbl_sram_slave_bytelane_mem.sv
// Word-addressed storage split into four byte lanes; per-lane write strobe, asynchronous read.
module ahbl_sram_bytelane_mem #(
   parameter int DEPTH = 256,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    wstrb,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (wstrb[l]) begin
            mem_q[idx][l] <= wdata[8*l +: 8];
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave: address-phase decode, fixed wait-state insertion and two-cycle ERROR response.
module ahbl_sram_slave
   import ahbl_package::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   HSEL,
   input  logic [ADDR_WIDTH-1:0]  HADDR,
   input  logic                   HWRITE,
   input  logic [SIZE_WIDTH-1:0]  HSIZE,
   input  logic [BURST_WIDTH-1:0] HBURST,
   input  logic [TRANS_WIDTH-1:0] HTRANS,
   input  logic [PROT_WIDTH-1:0]  HPROT,
   input  logic                   HMAST_LOCK,
   input  logic [WDATA_WIDTH-1:0] HWDATA,
   input  logic                   HREADY,
   output logic                   HREADYOUT,
   output logic                   HRESP,
   output logic [WDATA_WIDTH-1:0] HRDATA
);

   localparam int AW = $clog2(DEPTH * 4);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);

   slave_state_e          state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  write_q, write_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic                  err_q, err_d;
   logic [CW-1:0]         count_q, count_d;

   logic                  accept;
   logic                  addr_err;
   logic [3:0]            wstrb;
   logic [31:0]           mem_rdata;
   logic                  unused_inputs;

   assign unused_inputs = ^{HBURST, HPROT, HMAST_LOCK};

   assign accept   = HSEL && HREADY && HTRANS[1];
   assign addr_err = (HADDR >= ADDR_LIMIT) ||
                     (HSIZE > SIZE_WORD) ||
                     ((HSIZE == SIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));

   // IDLE, DATA and ERR2 all present HREADYOUT high, so each can take the next address phase.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      err_d   = err_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            state_d = ST_IDLE;
            if (accept) begin
               addr_d  = HADDR[AW-1:0];
               write_d = HWRITE;
               size_d  = HSIZE;
               err_d   = addr_err;
               if (addr_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  count_d = CW'(WAIT_STATES);
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_WAIT: begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = ST_DATA;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   // A reset arriving on the closing edge of a write data phase cancels the write.
   assign wstrb = (state_q == ST_DATA && write_q && !err_q && !HRESET)
                  ? lane_strobe(size_q, addr_q[1:0]) : 4'b0000;

   ahbl_sram_bytelane_mem #(
      .DEPTH (DEPTH),
      .IW    (AW - 2)
   ) u_mem (
      .clk   (HCLK),
      .wstrb (wstrb),
      .idx   (addr_q[AW-1:2]),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

   assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
   assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
   assign HRDATA    = (state_q == ST_DATA && !write_q) ? mem_rdata : '0;

endmodule
